// File: rtl/nios_system_bme_spi_pkg.sv
// rtl/nios_system_bme_spi_pkg.sv - shared state, register map and status bit definitions
package nios_system_bme_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_LAST,
        ST_DONE
    } state_t;

    localparam logic [1:0] ADDR_TXDATA  = 2'd0;
    localparam logic [1:0] ADDR_RXDATA  = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_CONTROL = 2'd3;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_OVERRUN  = 2;

endpackage

// File: rtl/nios_system_bme_spi_if.sv
// rtl/nios_system_bme_spi_if.sv - Avalon-MM register bus and SPI pins bundle
interface nios_system_bme_spi_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_miso;

    modport slave (
        input  address, chipselect, write_n, writedata, spi_miso,
        output readdata, spi_sclk, spi_mosi, spi_cs_n
    );

    modport master (
        output address, chipselect, write_n, writedata, spi_miso,
        input  readdata, spi_sclk, spi_mosi, spi_cs_n
    );

endinterface

// File: rtl/nios_system_bme_spi_clkgen.sv
// rtl/nios_system_bme_spi_clkgen.sv - SCLK divider with rise/fall strobes
module nios_system_bme_spi_clkgen #(
    parameter int HALF_DIV = 25
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] DIV_LAST = 8'(HALF_DIV - 1);

    logic [7:0] div_cnt;
    logic       wrap;

    // Strobes mark the clk cycle whose closing edge moves sclk.
    assign wrap = en && (div_cnt == DIV_LAST);
    assign rise = wrap && !sclk;
    assign fall = wrap && sclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/nios_system_bme_spi.sv
// rtl/nios_system_bme_spi.sv - Avalon-MM SPI master (mode 0) for a BME sensor
module nios_system_bme_spi
    import nios_system_bme_spi_pkg::*;
#(
    parameter int HALF_DIV = 25,
    parameter int CS_SETUP = 2
) (
    input logic                  clk,
    input logic                  reset_n,
    nios_system_bme_spi_if.slave bus
);

    localparam logic [7:0] SETUP_LAST = (CS_SETUP > 1) ? 8'(CS_SETUP - 1) : 8'd0;
    localparam logic [7:0] LAST_END   = 8'(HALF_DIV - 1);

    state_t      state;
    logic [7:0]  tx_shreg;
    logic [7:0]  rx_shreg;
    logic [7:0]  rx_data;
    logic [7:0]  wait_cnt;
    logic [2:0]  bit_cnt;
    logic        bit_term;
    logic        rx_valid;
    logic        overrun;
    logic        cs_hold;
    logic        miso_meta;
    logic        miso_sync;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        wr_en;
    logic        tx_wr;
    logic        rx_rd;
    logic        ovr_clr;
    logic        hold_nxt;
    logic        busy;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign wr_en    = bus.chipselect && !bus.write_n;
    assign tx_wr    = wr_en && (bus.address == ADDR_TXDATA);
    assign rx_rd    = bus.chipselect && bus.write_n && (bus.address == ADDR_RXDATA);
    assign ovr_clr  = wr_en && (bus.address == ADDR_STATUS) && bus.writedata[STAT_OVERRUN];
    assign hold_nxt = (wr_en && (bus.address == ADDR_CONTROL)) ? bus.writedata[0] : cs_hold;
    assign busy     = (state != ST_IDLE);
    assign unused_wdata = ^bus.writedata[31:8];

    nios_system_bme_spi_clkgen #(.HALF_DIV(HALF_DIV)) u_clkgen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state == ST_SHIFT),
        .sclk    (bus.spi_sclk),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            tx_shreg     <= '0;
            rx_shreg     <= '0;
            wait_cnt     <= '0;
            bit_cnt      <= '0;
            bit_term     <= 1'b0;
            bus.spi_mosi <= 1'b0;
            bus.spi_cs_n <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.spi_cs_n <= ~hold_nxt;
                    if (tx_wr) begin
                        state        <= ST_SETUP;
                        tx_shreg     <= bus.writedata[7:0];
                        bus.spi_mosi <= bus.writedata[7];
                        bus.spi_cs_n <= 1'b0;
                        wait_cnt     <= '0;
                        bit_cnt      <= '0;
                        bit_term     <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (wait_cnt == SETUP_LAST) begin
                        state    <= ST_SHIFT;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_shreg <= {rx_shreg[6:0], miso_sync};
                    end
                    // Falling edges advance MOSI; the eighth one ends the byte.
                    if (sclk_fall) begin
                        if (bit_term) begin
                            state        <= ST_LAST;
                            bus.spi_mosi <= 1'b0;
                        end else begin
                            tx_shreg     <= {tx_shreg[6:0], 1'b0};
                            bus.spi_mosi <= tx_shreg[6];
                            bit_cnt      <= bit_cnt + 3'd1;
                            bit_term     <= (bit_cnt == 3'd6);
                        end
                    end
                end
                ST_LAST: begin
                    if (wait_cnt == LAST_END) begin
                        state    <= ST_DONE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state        <= ST_IDLE;
                    bus.spi_cs_n <= ~hold_nxt;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_RXDATA: rd_mux[7:0] = rx_data;
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY]     = busy;
                rd_mux[STAT_RX_VALID] = rx_valid;
                rd_mux[STAT_OVERRUN]  = overrun;
            end
            ADDR_CONTROL: rd_mux[0] = cs_hold;
            default: rd_mux = '0;
        endcase
    end

    // Sticky flags: a completing byte takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_meta    <= 1'b0;
            miso_sync    <= 1'b0;
            cs_hold      <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            overrun      <= 1'b0;
            bus.readdata <= '0;
        end else begin
            miso_meta    <= bus.spi_miso;
            miso_sync    <= miso_meta;
            cs_hold      <= hold_nxt;
            bus.readdata <= rd_mux;
            if (state == ST_DONE) begin
                rx_data  <= rx_shreg;
                rx_valid <= 1'b1;
                if (rx_valid) begin
                    overrun <= 1'b1;
                end else if (ovr_clr) begin
                    overrun <= 1'b0;
                end
            end else begin
                if (rx_rd) begin
                    rx_valid <= 1'b0;
                end
                if (ovr_clr) begin
                    overrun <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_nios_system_bme_spi.sv
// tb/tb_nios_system_bme_spi.sv - randomized bench with mode-0 sensor models and register model
module tb_nios_system_bme_spi;
    import nios_system_bme_spi_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nios_system_bme_spi_if bus0();
    nios_system_bme_spi_if bus1();

    nios_system_bme_spi u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    nios_system_bme_spi #(.HALF_DIV(1), .CS_SETUP(2)) u_fast (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    int total = 0;
    int bad = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Mode-0 sensor: next bit appears after each falling edge, MSB ready once cs_n drops.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] sh0, sh1;
    int idx0, idx1;
    logic cs_prev0 = 1'b1, cs_prev1 = 1'b1;
    logic miso0 = 1'b0, miso1 = 1'b0;
    assign bus0.spi_miso = miso0;
    assign bus1.spi_miso = miso1;

    initial forever begin
        @(bus0.spi_cs_n or negedge bus0.spi_sclk);
        if (bus0.spi_cs_n !== cs_prev0) begin
            cs_prev0 = bus0.spi_cs_n;
            if (cs_prev0 === 1'b0) begin
                idx0 = 0;
                sh0 = 8'h00;
                if (q0.size() > 0) sh0 = q0.pop_front();
                #1 miso0 = sh0[7];
            end
        end else if (bus0.spi_cs_n === 1'b0 && bus0.spi_sclk === 1'b0) begin
            idx0++;
            if (idx0 == 8) begin
                idx0 = 0;
                if (q0.size() > 0) sh0 = q0.pop_front();
            end
            #1 miso0 = sh0[7 - idx0];
        end
    end

    initial forever begin
        @(bus1.spi_cs_n or negedge bus1.spi_sclk);
        if (bus1.spi_cs_n !== cs_prev1) begin
            cs_prev1 = bus1.spi_cs_n;
            if (cs_prev1 === 1'b0) begin
                idx1 = 0;
                sh1 = 8'h00;
                if (q1.size() > 0) sh1 = q1.pop_front();
                #1 miso1 = sh1[7];
            end
        end else if (bus1.spi_cs_n === 1'b0 && bus1.spi_sclk === 1'b0) begin
            idx1++;
            if (idx1 == 8) begin
                idx1 = 0;
                if (q1.size() > 0) sh1 = q1.pop_front();
            end
            #1 miso1 = sh1[7 - idx1];
        end
    end

    int rises0 = 0, rises1 = 0, cs_rises0 = 0;
    logic [7:0] mcap0 = 8'h00, mcap1 = 8'h00;
    time rt1[8];

    always @(posedge bus0.spi_sclk) begin
        rises0++;
        mcap0 = {mcap0[6:0], bus0.spi_mosi};
    end

    always @(posedge bus1.spi_sclk) begin
        rt1[rises1 % 8] = $time;
        rises1++;
        mcap1 = {mcap1[6:0], bus1.spi_mosi};
    end

    always @(posedge bus0.spi_cs_n) cs_rises0++;

    task automatic bus_write(input int inst, input logic [1:0] a, input logic [31:0] d);
        if (inst == 0) begin
            bus0.address = a; bus0.writedata = d; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        end else begin
            bus1.address = a; bus1.writedata = d; bus1.chipselect = 1'b1; bus1.write_n = 1'b0;
        end
        @(posedge clk); #1;
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
    endtask

    task automatic bus_read(input int inst, input logic [1:0] a, output logic [31:0] d);
        if (inst == 0) begin
            bus0.address = a; bus0.chipselect = 1'b1; bus0.write_n = 1'b1;
        end else begin
            bus1.address = a; bus1.chipselect = 1'b1; bus1.write_n = 1'b1;
        end
        @(posedge clk); #1;
        d = (inst == 0) ? bus0.readdata : bus1.readdata;
        bus0.chipselect = 1'b0;
        bus1.chipselect = 1'b0;
    endtask

    task automatic wait_idle(input int inst, input string tag);
        logic [31:0] s;
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            bus_read(inst, ADDR_STATUS, s);
            if (!s[STAT_BUSY]) done = 1'b1;
        end
        expect_eq({tag, "_idle"}, {31'd0, done}, 32'd1);
    endtask

    // Register-level reference: each finished byte sets valid, a second unread one flags overrun.
    logic m_valid = 1'b0, m_ovr = 1'b0;
    logic [7:0] m_rx = 8'h00;

    task automatic model_done(input logic [7:0] resp);
        m_ovr = m_ovr | m_valid;
        m_valid = 1'b1;
        m_rx = resp;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] s;
        bus_read(0, ADDR_STATUS, s);
        expect_eq(tag, s, {29'd0, m_ovr, m_valid, 1'b0});
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] d;
        bus_read(0, ADDR_RXDATA, d);
        expect_eq(tag, d, {24'd0, m_rx});
        m_valid = 1'b0;
    endtask

    task automatic xfer0(input logic [7:0] tx, input string tag);
        int r0;
        r0 = rises0;
        bus_write(0, ADDR_TXDATA, {24'd0, tx});
        wait_idle(0, tag);
        expect_eq({tag, "_rises"}, rises0 - r0, 32'd8);
        expect_eq({tag, "_mosi"}, {24'd0, mcap0}, {24'd0, tx});
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0] tx, rs, r1, r2;
        int r0, c0, nbad;

        bus0.address = '0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
        bus1.address = '0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("rst_cs_n", {31'd0, bus0.spi_cs_n}, 32'd1);
        expect_eq("rst_sclk", {31'd0, bus0.spi_sclk}, 32'd0);
        expect_eq("rst_mosi", {31'd0, bus0.spi_mosi}, 32'd0);
        expect_eq("rst_readdata", bus0.readdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_status("rst_status");
        bus_read(0, ADDR_CONTROL, rd);
        expect_eq("rst_control", rd, 32'd0);
        check_rx("rst_rxdata");

        q0.push_back(8'h60);
        xfer0(8'hD0, "basic");
        model_done(8'h60);
        expect_eq("basic_cs_n", {31'd0, bus0.spi_cs_n}, 32'd1);
        check_status("basic_status");
        check_rx("basic_rx");
        check_status("basic_status_clr");

        tx = 8'($urandom); rs = 8'($urandom);
        q0.push_back(rs);
        r0 = rises0;
        bus_write(0, ADDR_TXDATA, {24'd0, tx});
        for (int i = 0; i < 2000 && (rises0 - r0) < 2; i++) @(posedge clk);
        #1;
        expect_eq("busywr_reach", {31'd0, (rises0 - r0) >= 2}, 32'd1);
        bus_write(0, ADDR_TXDATA, 32'h55);
        wait_idle(0, "busywr");
        expect_eq("busywr_mosi", {24'd0, mcap0}, {24'd0, tx});
        repeat (60) @(posedge clk);
        #1;
        expect_eq("busywr_rises", rises0 - r0, 32'd8);
        expect_eq("busywr_cs_n", {31'd0, bus0.spi_cs_n}, 32'd1);
        model_done(rs);
        check_status("busywr_status");
        check_rx("busywr_rx");

        r1 = 8'($urandom); r2 = 8'($urandom);
        q0.push_back(r1);
        q0.push_back(r2);
        bus_write(0, ADDR_CONTROL, 32'd1);
        expect_eq("hold_cs_low", {31'd0, bus0.spi_cs_n}, 32'd0);
        c0 = cs_rises0;
        xfer0(8'hF7, "hold1");
        model_done(r1);
        expect_eq("hold1_cs_n", {31'd0, bus0.spi_cs_n}, 32'd0);
        check_rx("hold1_rx");
        xfer0(8'h00, "hold2");
        model_done(r2);
        expect_eq("hold_cs_rises", cs_rises0 - c0, 32'd0);
        check_rx("hold2_rx");
        bus_write(0, ADDR_CONTROL, 32'd0);
        expect_eq("hold_release", {31'd0, bus0.spi_cs_n}, 32'd1);
        check_status("hold_status");

        for (int n = 0; n < 8; n++) begin
            tx = 8'($urandom); rs = 8'($urandom);
            q0.push_back(rs);
            xfer0(tx, "rand");
            model_done(rs);
            check_status("rand_status");
            if ($urandom_range(0, 1) == 1) check_rx("rand_rx");
            if ($urandom_range(0, 2) == 0) begin
                bus_write(0, ADDR_STATUS, 32'h4);
                m_ovr = 1'b0;
            end
        end

        check_rx("ovr_pre_rx");
        bus_write(0, ADDR_STATUS, 32'h4);
        m_ovr = 1'b0;
        r1 = 8'($urandom); r2 = 8'($urandom);
        q0.push_back(r1);
        xfer0(8'($urandom), "ovr1");
        model_done(r1);
        q0.push_back(r2);
        xfer0(8'($urandom), "ovr2");
        model_done(r2);
        check_status("ovr_status");
        check_rx("ovr_rx");
        check_status("ovr_after_rd");
        bus_write(0, ADDR_STATUS, 32'h4);
        m_ovr = 1'b0;
        check_status("ovr_cleared");

        rs = 8'($urandom);
        q0.push_back(rs);
        xfer0(8'($urandom), "pre_rst");
        model_done(rs);
        bus_write(0, ADDR_CONTROL, 32'd1);
        r0 = rises0;
        bus_write(0, ADDR_TXDATA, 32'h3C);
        for (int i = 0; i < 2000 && (rises0 - r0) < 4; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        expect_eq("midrst_reach", {31'd0, (rises0 - r0) >= 4}, 32'd1);
        reset_n = 1'b0;
        #1;
        expect_eq("midrst_cs_n", {31'd0, bus0.spi_cs_n}, 32'd1);
        expect_eq("midrst_sclk", {31'd0, bus0.spi_sclk}, 32'd0);
        expect_eq("midrst_mosi", {31'd0, bus0.spi_mosi}, 32'd0);
        expect_eq("midrst_readdata", bus0.readdata, 32'd0);
        m_valid = 1'b0; m_ovr = 1'b0; m_rx = 8'h00;
        q0.delete();
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        check_status("midrst_status");
        bus_read(0, ADDR_CONTROL, rd);
        expect_eq("midrst_control", rd, 32'd0);
        check_rx("midrst_rx");
        r0 = rises0;
        repeat (60) @(posedge clk);
        #1;
        expect_eq("midrst_no_start", rises0 - r0, 32'd0);
        expect_eq("midrst_cs_idle", {31'd0, bus0.spi_cs_n}, 32'd1);
        rs = 8'($urandom);
        q0.push_back(rs);
        xfer0(8'hA5, "post_rst");
        model_done(rs);
        check_status("post_rst_status");
        check_rx("post_rst_rx");

        for (int n = 0; n < 5; n++) begin
            tx = (n == 0) ? 8'hFF : 8'($urandom);
            rs = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            q1.push_back(rs);
            r0 = rises1;
            bus_write(1, ADDR_TXDATA, {24'd0, tx});
            wait_idle(1, "fast");
            expect_eq("fast_rises", rises1 - r0, 32'd8);
            expect_eq("fast_mosi", {24'd0, mcap1}, {24'd0, tx});
            nbad = 0;
            for (int k = 1; k < 8; k++)
                if (rt1[(rises1 - 8 + k) % 8] - rt1[(rises1 - 9 + k) % 8] != 20) nbad++;
            expect_eq("fast_period", nbad, 32'd0);
            bus_read(1, ADDR_RXDATA, rd);
            expect_eq("fast_rx", rd, {24'd0, rs});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
